// File: rtl/simple_9_sel_arb_if.sv
// Request/grant bundle between the sources, the consumer and the select arbiter.
interface simple_9_sel_arb_if;
  logic [3:0] req;
  logic       last;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       burst_cut;

  // Requesters and consumer side: drive requests and end-of-transfer.
  modport master (
    output req,
    output last,
    input  sel,
    input  grant,
    input  busy,
    input  burst_cut
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  last,
    output sel,
    output grant,
    output busy,
    output burst_cut
  );
endinterface

// File: rtl/simple_9_sel_arb.sv
// Round-robin select generator for a 4:1 data selector. Holds one grant per
// burst and hands over to the next requester without a dead cycle.
module simple_9_sel_arb #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  simple_9_sel_arb_if.slave bus
);

  localparam int unsigned   CntW   = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      sel_q;
  logic [3:0]      grant_q;
  logic            busy_q;
  logic            cut_q;

  logic [1:0]      pick_ch;
  logic            cur_req;
  logic            at_max;
  logic            burst_end;

  // First requester after base, wrapping round so base itself is checked last.
  function automatic logic [1:0] pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] res;
    logic [1:0] c;
    res = base;
    for (int k = 3; k >= 1; k--) begin
      c = base + 2'(k);
      if (r[c]) res = c;
    end
    return res;
  endfunction

  // Arbitration and burst-termination terms; ptr_q always equals the current
  // channel while a grant is held.
  always_comb begin
    pick_ch   = pick(ptr_q, bus.req);
    cur_req   = bus.req[sel_q];
    at_max    = (cnt_q == CntMax);
    burst_end = bus.last | ~cur_req | at_max;
  end

  // Grant FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
      cut_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cut_q <= 1'b0;
          // sel_q is left alone so the selector keeps a defined input.
          if (|bus.req) begin
            state_q <= StGrant;
            sel_q   <= pick_ch;
            grant_q <= 4'b0001 << pick_ch;
            busy_q  <= 1'b1;
            cnt_q   <= CntOne;
            ptr_q   <= pick_ch;
          end
        end
        StGrant: begin
          if (!burst_end) begin
            cnt_q <= cnt_q + CntOne;
            cut_q <= 1'b0;
          end else begin
            // Flag only a burst that would otherwise have continued.
            cut_q <= at_max & ~bus.last & cur_req;
            if (|bus.req) begin
              sel_q   <= pick_ch;
              grant_q <= 4'b0001 << pick_ch;
              cnt_q   <= CntOne;
              ptr_q   <= pick_ch;
            end else begin
              state_q <= StIdle;
              grant_q <= 4'b0000;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.burst_cut = cut_q;

endmodule

// File: tb/tb_simple_9_sel_arb.sv
// Bench for simple_9_sel_arb: directed scenarios with literal expectations
// plus a randomized run, all cross-checked every cycle against a
// behavioural round-robin model.
module tb_simple_9_sel_arb;

  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  simple_9_sel_arb_if bus ();

  simple_9_sel_arb #(.MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_busy = 1'b0;
  int m_ch   = 0;   // channel driven on sel
  int m_ptr  = 3;   // most recently granted channel
  int m_len  = 0;   // beats the current grant has been held
  bit m_cut  = 1'b0;

  bit n_busy;
  int n_ch;
  int n_ptr;
  int n_len;
  bit n_cut;

  function automatic int rr_next(input int last_ch, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last_ch + k) % 4]) return (last_ch + k) % 4;
    end
    return last_ch;
  endfunction

  // Next model state from the arbitration rules.
  always_comb begin
    n_busy = m_busy;
    n_ch   = m_ch;
    n_ptr  = m_ptr;
    n_len  = m_len;
    n_cut  = 1'b0;
    if (!m_busy) begin
      if (bus.req != 4'b0000) begin
        n_ch   = rr_next(m_ptr, bus.req);
        n_ptr  = n_ch;
        n_busy = 1'b1;
        n_len  = 1;
      end
    end else if (!(bus.last || !bus.req[m_ch] || m_len == MB)) begin
      n_len = m_len + 1;
    end else begin
      n_cut = (m_len == MB) && !bus.last && bus.req[m_ch];
      if (bus.req != 4'b0000) begin
        n_ch  = rr_next(m_ch, bus.req);
        n_ptr = n_ch;
        n_len = 1;
      end else begin
        n_busy = 1'b0;
        n_len  = 0;
      end
    end
  end

  // Model state update.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_ch   <= 0;
      m_ptr  <= 3;
      m_len  <= 0;
      m_cut  <= 1'b0;
    end else begin
      m_busy <= n_busy;
      m_ch   <= n_ch;
      m_ptr  <= n_ptr;
      m_len  <= n_len;
      m_cut  <= n_cut;
    end
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b required %b", name, $time, got, exp);
    end
  endtask

  // Compare DUT outputs with the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_sel", {2'b00, bus.sel}, 4'(m_ch));
      chk("model_grant", bus.grant, m_busy ? (4'b0001 << m_ch) : 4'b0000);
      chk("model_busy", {3'b000, bus.busy}, {3'b000, m_busy});
      chk("model_cut", {3'b000, bus.burst_cut}, {3'b000, m_cut});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.req  = 4'b0000;
    bus.last = 1'b0;

    // Reset and first grant.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_sel", {2'b00, bus.sel}, 4'b0000);
      chk("idle_grant", bus.grant, 4'b0000);
      chk("idle_busy", {3'b000, bus.busy}, 4'b0000);
      chk("idle_cut", {3'b000, bus.burst_cut}, 4'b0000);
    end
    tick();
    bus.req = 4'b1010;
    tick();
    @(negedge clk);
    chk("first_sel", {2'b00, bus.sel}, 4'b0001);
    chk("first_grant", bus.grant, 4'b0010);
    chk("first_busy", {3'b000, bus.busy}, 4'b0001);

    // Rotation: all request, last on every second beat.
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.last = (i % 2 == 1);
      @(negedge clk);
      chk("rot_grant", bus.grant, 4'b0001 << ((i / 2) % 4));
      chk("rot_cut", {3'b000, bus.burst_cut}, 4'b0000);
    end
    bus.last = 1'b0;

    // Expiry: two requesters, no last.
    do_reset();
    bus.req = 4'b0101;
    for (int i = 0; i < 16; i++) begin
      tick();
      @(negedge clk);
      chk("exp_grant", bus.grant, ((i / 4) % 2 == 1) ? 4'b0100 : 4'b0001);
      chk("exp_cut", {3'b000, bus.burst_cut}, {3'b000, (i % 4 == 0 && i > 0)});
    end

    // last coinciding with expiry, then granted request dropping mid-burst.
    do_reset();
    bus.req = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.last = (i == 3);
      if (i == 5) bus.req = 4'b0001;
      if (i == 6) bus.req = 4'b0000;
      @(negedge clk);
      if (i == 4) begin
        chk("sim_last_grant", bus.grant, 4'b0100);
        chk("sim_last_cut", {3'b000, bus.burst_cut}, 4'b0000);
      end
      if (i == 6) chk("drop_grant", bus.grant, 4'b0001);
      if (i == 7) chk("drop_idle", {3'b000, bus.busy}, 4'b0000);
    end

    // Sole requester with last every beat, then reset mid-burst.
    do_reset();
    bus.req  = 4'b0100;
    bus.last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      chk("sole_grant", bus.grant, 4'b0100);
      chk("sole_busy", {3'b000, bus.busy}, 4'b0001);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", {2'b00, bus.sel}, 4'b0000);
    chk("arst_grant", bus.grant, 4'b0000);
    chk("arst_busy", {3'b000, bus.busy}, 4'b0000);
    chk("arst_cut", {3'b000, bus.burst_cut}, 4'b0000);
    bus.req  = 4'b1111;
    bus.last = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_grant", bus.grant, 4'b0001);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(3) == 0) bus.req = 4'($urandom);
      bus.last = ($urandom_range(3) == 0);
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
